// File: rtl/vending_machine_param_if.sv
// Bundle of coin/button inputs and dispenser/hopper outputs shared by the
// front-end debouncers, the vending controller and the dispenser drivers.
interface vending_machine_param_if #(
    parameter int N_ITEMS = 4,
    parameter int MONEY_W = 12
);
    // Protocol: inputs are debounced levels and only their rising edges act.
    // There is no back-pressure; edges that arrive while busy are rejected
    // (coins) or ignored (buy/coin_return). Outputs other than money, busy,
    // out_of_stock and state are one-cycle pulses.
    logic               quarter;
    logic               dollar;
    logic [N_ITEMS-1:0] select;
    logic               buy;
    logic               coin_return;
    logic [N_ITEMS-1:0] load;
    logic [MONEY_W-1:0] money;
    logic [N_ITEMS-1:0] products;
    logic [N_ITEMS-1:0] out_of_stock;
    logic               change_quarter;
    logic               busy;
    logic               vend_fail;
    logic               coin_reject;
    logic [1:0]         state;

    modport master (
        output quarter, dollar, select, buy, coin_return, load,
        input  money, products, out_of_stock, change_quarter, busy,
               vend_fail, coin_reject, state
    );

    modport slave (
        input  quarter, dollar, select, buy, coin_return, load,
        output money, products, out_of_stock, change_quarter, busy,
               vend_fail, coin_reject, state
    );
endinterface

// File: rtl/vending_machine_param.sv
// Multi-tray vending controller: coin credit with ceiling, per-tray stock with
// refill, single-cycle vend and quarter-by-quarter change payout.
module vending_machine_param #(
    parameter int                         N_ITEMS    = 4,
    parameter int                         STOCK_W    = 4,
    parameter int                         MONEY_W    = 12,
    parameter logic [N_ITEMS*MONEY_W-1:0] PRICES     = {12'd200, 12'd150, 12'd75, 12'd25},
    parameter int                         MAX_CREDIT = 1000
) (
    input logic                    clk,
    input logic                    reset,
    vending_machine_param_if.slave bus
);
    localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam logic [STOCK_W-1:0] FULL    = '1;
    localparam logic [MONEY_W-1:0] QUARTER = MONEY_W'(25);
    localparam logic [MONEY_W:0]   Q_VAL   = (MONEY_W + 1)'(25);
    localparam logic [MONEY_W:0]   D_VAL   = (MONEY_W + 1)'(100);
    localparam logic [MONEY_W:0]   MAX_SUM = (MONEY_W + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               quarter_prev, dollar_prev, buy_prev, coin_return_prev;
    logic               quarter_edge, dollar_edge, buy_edge, coin_return_edge, coin_edge;
    logic [MONEY_W-1:0] money_q, money_d;
    logic [IDX_W-1:0]   idx_q, idx_d, sel_idx;
    logic               sel_onehot, buy_ok;
    logic [MONEY_W:0]   coin_value, credit_sum;
    logic [N_ITEMS-1:0] products_q, products_d;
    logic [N_ITEMS-1:0] oos_q;
    logic               change_quarter_q, change_quarter_d;
    logic               vend_fail_q, vend_fail_d;
    logic               coin_reject_q, coin_reject_d;
    logic [STOCK_W-1:0] stock_q [N_ITEMS];

    function automatic logic [MONEY_W-1:0] price_of(input logic [IDX_W-1:0] idx);
        price_of = PRICES[int'(idx)*MONEY_W +: MONEY_W];
    endfunction

    assign quarter_edge     = bus.quarter & ~quarter_prev;
    assign dollar_edge      = bus.dollar & ~dollar_prev;
    assign buy_edge         = bus.buy & ~buy_prev;
    assign coin_return_edge = bus.coin_return & ~coin_return_prev;
    assign coin_edge        = quarter_edge | dollar_edge;
    assign coin_value       = (quarter_edge ? Q_VAL : '0) + (dollar_edge ? D_VAL : '0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (bus.select[i]) sel_idx = IDX_W'(i);
        end
    end

    assign sel_onehot = (bus.select != '0) && ((bus.select & (bus.select - 1'b1)) == '0);
    // Price check uses credit before any coin landing in the same cycle.
    assign buy_ok     = sel_onehot && (stock_q[sel_idx] != '0) && (money_q >= price_of(sel_idx));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a buy edge always wins over coin_return
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (buy_edge) begin
                    if (buy_ok) state_d = VEND;
                end else if (coin_return_edge && (money_q != '0)) begin
                    state_d = CHANGE;
                end
            end
            VEND:    state_d = IDLE;
            CHANGE:  if (money_q <= QUARTER) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        money_d          = money_q;
        idx_d            = idx_q;
        products_d       = '0;
        change_quarter_d = 1'b0;
        vend_fail_d      = 1'b0;
        coin_reject_d    = 1'b0;
        credit_sum       = {1'b0, money_q} + coin_value;
        case (state_q)
            IDLE: begin
                if (coin_value != '0) begin
                    if (credit_sum <= MAX_SUM) money_d = credit_sum[MONEY_W-1:0];
                    else                       coin_reject_d = 1'b1;
                end
                if (buy_edge) begin
                    if (buy_ok) idx_d = sel_idx;
                    else        vend_fail_d = 1'b1;
                end
            end
            VEND: begin
                coin_reject_d       = coin_edge;
                products_d[idx_q]   = 1'b1;
                money_d = (money_q >= price_of(idx_q)) ? money_q - price_of(idx_q) : '0;
            end
            CHANGE: begin
                coin_reject_d = coin_edge;
                if (money_q >= QUARTER) begin
                    money_d          = money_q - QUARTER;
                    change_quarter_d = 1'b1;
                end else begin
                    money_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quarter_prev     <= 1'b0;
            dollar_prev      <= 1'b0;
            buy_prev         <= 1'b0;
            coin_return_prev <= 1'b0;
            money_q          <= '0;
            idx_q            <= '0;
            products_q       <= '0;
            change_quarter_q <= 1'b0;
            vend_fail_q      <= 1'b0;
            coin_reject_q    <= 1'b0;
            oos_q            <= '0;
        end else begin
            quarter_prev     <= bus.quarter;
            dollar_prev      <= bus.dollar;
            buy_prev         <= bus.buy;
            coin_return_prev <= bus.coin_return;
            money_q          <= money_d;
            idx_q            <= idx_d;
            products_q       <= products_d;
            change_quarter_q <= change_quarter_d;
            vend_fail_q      <= vend_fail_d;
            coin_reject_q    <= coin_reject_d;
            for (int i = 0; i < N_ITEMS; i++) oos_q[i] <= (stock_q[i] == '0);
        end
    end

    // Refill beats a same-cycle vend decrement of the same tray
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= FULL;
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (bus.load[i])
                    stock_q[i] <= FULL;
                else if ((state_q == VEND) && (idx_q == IDX_W'(i)) && (stock_q[i] != '0))
                    stock_q[i] <= stock_q[i] - 1'b1;
            end
        end
    end

    assign bus.money          = money_q;
    assign bus.products       = products_q;
    assign bus.out_of_stock   = oos_q;
    assign bus.change_quarter = change_quarter_q;
    assign bus.vend_fail      = vend_fail_q;
    assign bus.coin_reject    = coin_reject_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.state          = state_q;
endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed scenarios plus a randomized run,
// all checked against a transaction-level credit/stock model.
module tb_vending_machine_param;
    localparam int PRICE_TAB [4] = '{25, 75, 150, 200};
    localparam int FULL_STOCK = 15;
    localparam int MAX_C = 1000;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad = 0;

    // behavioural model state
    int m;
    int stk [4];

    vending_machine_param_if #(.N_ITEMS(4), .MONEY_W(12)) bus ();

    vending_machine_param #(
        .N_ITEMS(4), .STOCK_W(4), .MONEY_W(12),
        .PRICES({12'd200, 12'd150, 12'd75, 12'd25}), .MAX_CREDIT(1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- clock / drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coin(input logic q, input logic d, output logic rej);
        bus.quarter = q;
        bus.dollar  = d;
        tick();
        rej = bus.coin_reject;
        bus.quarter = 1'b0;
        bus.dollar  = 1'b0;
        tick();
    endtask

    task automatic drive_buy(input logic [3:0] sel, input logic [3:0] ld, output logic vf,
                             output logic bsy, output logic [3:0] prod1, output logic [3:0] prod2);
        bus.select = sel;
        bus.buy    = 1'b1;
        tick();
        vf  = bus.vend_fail;
        bsy = bus.busy;
        bus.buy  = 1'b0;
        bus.load = ld;
        tick();
        prod1 = bus.products;
        bus.load = 4'b0;
        tick();
        prod2 = bus.products;
    endtask

    task automatic drive_load(input logic [3:0] ld);
        bus.load = ld;
        tick();
        bus.load = 4'b0;
        tick();
    endtask

    task automatic drive_return(input logic dollar_in_change, output int pulses, output int ticks,
                                output logic rej, output logic bsy0);
        bus.coin_return = 1'b1;
        tick();
        bsy0 = bus.busy;
        bus.coin_return = 1'b0;
        pulses = 0;
        ticks  = 0;
        rej    = 1'b0;
        if (!bsy0) begin
            tick();
        end else begin
            if (dollar_in_change) bus.dollar = 1'b1;
            for (int i = 0; i < 100; i++) begin
                tick();
                ticks++;
                bus.dollar = 1'b0;
                if (bus.change_quarter) pulses++;
                if (bus.coin_reject) rej = 1'b1;
                if (!bus.busy) break;
            end
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m = 0;
        for (int i = 0; i < 4; i++) stk[i] = FULL_STOCK;
    endfunction

    function automatic void model_coin(input logic q, input logic d, output logic rej);
        int v;
        v = (q ? 25 : 0) + (d ? 100 : 0);
        rej = 1'b0;
        if (v > 0) begin
            if (m + v <= MAX_C) m = m + v;
            else rej = 1'b1;
        end
    endfunction

    function automatic void model_buy(input logic [3:0] sel, input logic [3:0] ld, output logic ok);
        int ones;
        int idx;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) begin ones++; idx = i; end
        ok = 1'b0;
        if (ones == 1) ok = (stk[idx] > 0) && (m >= PRICE_TAB[idx]);
        if (ok) begin
            m = m - PRICE_TAB[idx];
            stk[idx] = stk[idx] - 1;
        end
        for (int i = 0; i < 4; i++) if (ld[i]) stk[i] = FULL_STOCK;
    endfunction

    function automatic void model_return(output int pulses);
        pulses = m / 25;
        m = 0;
    endfunction

    function automatic void model_load(input logic [3:0] ld);
        for (int i = 0; i < 4; i++) if (ld[i]) stk[i] = FULL_STOCK;
    endfunction

    function automatic logic [3:0] exp_oos();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (stk[i] == 0);
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.quarter = 0; bus.dollar = 0; bus.select = 0; bus.buy = 0;
        bus.coin_return = 0; bus.load = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        total++; if (bus.money !== 12'd0) begin bad++; $display("FAIL reset_money: got %0d expected 0", bus.money); end
        total++; if (bus.products !== 4'b0) begin bad++; $display("FAIL reset_products: got %b expected 0000", bus.products); end
        total++; if (bus.out_of_stock !== 4'b0) begin bad++; $display("FAIL reset_oos: got %b expected 0000", bus.out_of_stock); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        total++; if ({bus.change_quarter, bus.vend_fail, bus.coin_reject} !== 3'b0) begin
            bad++; $display("FAIL reset_pulses: got %b expected 000", {bus.change_quarter, bus.vend_fail, bus.coin_reject}); end
    endtask

    task automatic test_coins();
        logic rej, erej;
        for (int i = 0; i < 4; i++) begin
            logic q, d;
            q = (i < 3);
            d = (i == 3);
            model_coin(q, d, erej);
            drive_coin(q, d, rej);
            total++; if (rej !== erej) begin bad++; $display("FAIL coin_reject_%0d: got %b expected %b", i, rej, erej); end
        end
        total++; if (bus.money !== 12'(m) || m != 175) begin bad++; $display("FAIL coins_money: got %0d expected 175", bus.money); end
    endtask

    task automatic test_vend();
        logic vf, bsy, ok;
        logic [3:0] p1, p2;
        model_buy(4'b0100, 4'b0, ok);
        drive_buy(4'b0100, 4'b0, vf, bsy, p1, p2);
        total++; if (vf !== 1'b0) begin bad++; $display("FAIL vend_ok_fail: got %b expected 0", vf); end
        total++; if (bsy !== 1'b1) begin bad++; $display("FAIL vend_busy: got %b expected 1", bsy); end
        total++; if (p1 !== 4'b0100) begin bad++; $display("FAIL vend_products: got %b expected 0100", p1); end
        total++; if (p2 !== 4'b0000) begin bad++; $display("FAIL vend_products_clear: got %b expected 0000", p2); end
        total++; if (bus.money !== 12'd25) begin bad++; $display("FAIL vend_money: got %0d expected 25", bus.money); end
        model_buy(4'b0110, 4'b0, ok);
        drive_buy(4'b0110, 4'b0, vf, bsy, p1, p2);
        total++; if (vf !== 1'b1) begin bad++; $display("FAIL vend_multi_sel: got %b expected 1", vf); end
        total++; if (p1 !== 4'b0) begin bad++; $display("FAIL vend_multi_products: got %b expected 0000", p1); end
        total++; if (bus.money !== 12'(m)) begin bad++; $display("FAIL vend_multi_money: got %0d expected %0d", bus.money, m); end
    endtask

    task automatic test_level_hold();
        bus.quarter = 1'b1;
        repeat (5) tick();
        bus.quarter = 1'b0;
        tick();
        m = m + 25;
        total++; if (bus.money !== 12'(m)) begin bad++; $display("FAIL hold_money: got %0d expected %0d", bus.money, m); end
        total++; if (bus.coin_reject !== 1'b0) begin bad++; $display("FAIL hold_reject: got %b expected 0", bus.coin_reject); end
    endtask

    task automatic test_ceiling();
        logic rej, erej, bsy0;
        int p, t, ep;
        model_return(ep);
        drive_return(1'b0, p, t, rej, bsy0);
        total++; if (p !== ep) begin bad++; $display("FAIL ceil_refund: got %0d expected %0d", p, ep); end
        for (int i = 0; i < 10; i++) begin model_coin(1'b0, 1'b1, erej); drive_coin(1'b0, 1'b1, rej); end
        total++; if (bus.money !== 12'd1000) begin bad++; $display("FAIL ceil_fill: got %0d expected 1000", bus.money); end
        model_coin(1'b1, 1'b0, erej);
        drive_coin(1'b1, 1'b0, rej);
        total++; if (rej !== 1'b1) begin bad++; $display("FAIL ceil_quarter_reject: got %b expected 1", rej); end
        total++; if (bus.money !== 12'd1000) begin bad++; $display("FAIL ceil_quarter_money: got %0d expected 1000", bus.money); end
        model_return(ep);
        drive_return(1'b0, p, t, rej, bsy0);
        total++; if (p !== 40) begin bad++; $display("FAIL ceil_refund_40: got %0d expected 40", p); end
        for (int i = 0; i < 9; i++) begin model_coin(1'b0, 1'b1, erej); drive_coin(1'b0, 1'b1, rej); end
        model_coin(1'b1, 1'b1, erej);
        drive_coin(1'b1, 1'b1, rej);
        total++; if (rej !== 1'b1) begin bad++; $display("FAIL ceil_both_reject: got %b expected 1", rej); end
        total++; if (bus.money !== 12'd900) begin bad++; $display("FAIL ceil_both_money: got %0d expected 900", bus.money); end
        model_return(ep);
        drive_return(1'b0, p, t, rej, bsy0);
        total++; if (bus.money !== 12'd0) begin bad++; $display("FAIL ceil_drain: got %0d expected 0", bus.money); end
    endtask

    task automatic test_change();
        logic rej, erej, bsy0;
        int p, t, ep;
        model_coin(1'b0, 1'b1, erej);
        drive_coin(1'b0, 1'b1, rej);
        model_return(ep);
        drive_return(1'b1, p, t, rej, bsy0);
        total++; if (p !== 4) begin bad++; $display("FAIL change_pulses: got %0d expected 4", p); end
        total++; if (t !== 4) begin bad++; $display("FAIL change_cycles: got %0d expected 4", t); end
        total++; if (rej !== 1'b1) begin bad++; $display("FAIL change_coin_reject: got %b expected 1", rej); end
        total++; if (bus.money !== 12'd0) begin bad++; $display("FAIL change_money: got %0d expected 0", bus.money); end
        drive_return(1'b0, p, t, rej, bsy0);
        total++; if (bsy0 !== 1'b0 || p !== 0) begin bad++; $display("FAIL change_zero: got busy %b pulses %0d expected 0 0", bsy0, p); end
    endtask

    task automatic test_stock();
        logic rej, erej, vf, bsy, ok;
        logic [3:0] p1, p2;
        for (int i = 0; i < 4; i++) begin model_coin(1'b0, 1'b1, erej); drive_coin(1'b0, 1'b1, rej); end
        for (int i = 0; i < 15; i++) begin model_buy(4'b0001, 4'b0, ok); drive_buy(4'b0001, 4'b0, vf, bsy, p1, p2); end
        total++; if (bus.out_of_stock !== 4'b0001) begin bad++; $display("FAIL stock_empty_oos: got %b expected 0001", bus.out_of_stock); end
        model_buy(4'b0001, 4'b0, ok);
        drive_buy(4'b0001, 4'b0, vf, bsy, p1, p2);
        total++; if (vf !== 1'b1) begin bad++; $display("FAIL stock_empty_buy: got %b expected 1", vf); end
        total++; if (bus.money !== 12'(m)) begin bad++; $display("FAIL stock_empty_money: got %0d expected %0d", bus.money, m); end
        model_load(4'b0001);
        drive_load(4'b0001);
        model_buy(4'b0001, 4'b0001, ok);
        drive_buy(4'b0001, 4'b0001, vf, bsy, p1, p2);
        total++; if (p1 !== 4'b0001) begin bad++; $display("FAIL stock_load_vend: got %b expected 0001", p1); end
        total++; if (bus.out_of_stock !== 4'b0000) begin bad++; $display("FAIL stock_load_oos: got %b expected 0000", bus.out_of_stock); end
        // tray 0 must hold exactly 15 again: empty only after the 15th buy
        for (int i = 0; i < 4; i++) begin model_coin(1'b0, 1'b1, erej); drive_coin(1'b0, 1'b1, rej); end
        for (int i = 0; i < 15; i++) begin
            model_buy(4'b0001, 4'b0, ok);
            drive_buy(4'b0001, 4'b0, vf, bsy, p1, p2);
            if (i >= 13) begin
                total++;
                if (bus.out_of_stock !== exp_oos()) begin
                    bad++; $display("FAIL stock_refill_count_%0d: got %b expected %b", i, bus.out_of_stock, exp_oos());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic rej, erej;
        while (m < 75) begin model_coin(1'b1, 1'b0, erej); drive_coin(1'b1, 1'b0, rej); end
        total++; if (bus.money !== 12'd75) begin bad++; $display("FAIL areset_setup: got %0d expected 75", bus.money); end
        bus.coin_return = 1'b1;
        tick();
        bus.coin_return = 1'b0;
        tick();
        total++; if (bus.money !== 12'd50 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL areset_mid_change: got money %0d busy %b expected 50 1", bus.money, bus.busy); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.money !== 12'd0) begin bad++; $display("FAIL areset_money: got %0d expected 0", bus.money); end
        total++; if ({bus.busy, bus.change_quarter, bus.vend_fail, bus.coin_reject, bus.products, bus.out_of_stock} !== 12'b0) begin
            bad++; $display("FAIL areset_outputs: got %b expected all zero",
                {bus.busy, bus.change_quarter, bus.vend_fail, bus.coin_reject, bus.products, bus.out_of_stock}); end
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        total++; if (bus.out_of_stock !== 4'b0 || bus.money !== 12'd0) begin
            bad++; $display("FAIL areset_after: got oos %b money %0d expected 0000 0", bus.out_of_stock, bus.money); end
    endtask

    task automatic test_random();
        logic rej, erej, vf, bsy, ok, bsy0;
        logic [3:0] p1, p2, sel, ld;
        int p, t, ep, op;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                logic q, d;
                q = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
                model_coin(q, d, erej);
                drive_coin(q, d, rej);
                total++; if (rej !== erej) begin bad++; $display("FAIL rnd_coin_%0d: got reject %b expected %b", n, rej, erej); end
            end else if (op <= 7) begin
                if ($urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 15));
                else sel = 4'b0001 << $urandom_range(0, 3);
                ld = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
                model_buy(sel, ld, ok);
                drive_buy(sel, ld, vf, bsy, p1, p2);
                total++; if (vf !== !ok) begin bad++; $display("FAIL rnd_buy_fail_%0d: got %b expected %b", n, vf, !ok); end
                total++; if (p1 !== (ok ? sel : 4'b0)) begin bad++; $display("FAIL rnd_buy_prod_%0d: got %b expected %b", n, p1, ok ? sel : 4'b0); end
            end else if (op == 8) begin
                model_return(ep);
                drive_return(1'b0, p, t, rej, bsy0);
                total++; if (p !== ep) begin bad++; $display("FAIL rnd_return_%0d: got %0d expected %0d", n, p, ep); end
            end else begin
                ld = 4'($urandom_range(0, 15));
                model_load(ld);
                drive_load(ld);
            end
            total++; if (bus.money !== 12'(m)) begin bad++; $display("FAIL rnd_money_%0d: got %0d expected %0d", n, bus.money, m); end
            total++; if (bus.out_of_stock !== exp_oos()) begin bad++; $display("FAIL rnd_oos_%0d: got %b expected %b", n, bus.out_of_stock, exp_oos()); end
        end
    endtask

    initial begin
        test_reset();
        test_coins();
        test_vend();
        test_level_hold();
        test_ceiling();
        test_change();
        test_stock();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
